pg_domain_sequencer: RTL and testbench

Ordered power-gate sequencer for the PMU. It drives the per-domain `power` requests of up to `N_DOM` PowerGateFSM/PowerGateFSM_MRAM instances and waits for each domain's `done` before stepping to the next one. Power-down runs from the highest index to the lowest; power-up runs in the reverse order. Each step has a programmable settle delay and a per-step timeout with a sticky error. It sits between the wakeup/sleep control (`is_sleeping`-style request) and the domain FSMs.

---
 rtl/pg_domain_sequencer.sv | 252 +++++++++++++++++++++++++
 tb/tb_pg_domain_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pg_domain_sequencer.sv
// ---------------------------------------------------------------------------
// pg_domain_sequencer
//
// Ordered power-gate sequencer. It drives the per-domain power requests of the
// domain FSMs one at a time and waits for each domain's done before moving on.
// Power-down walks the latched mask from the highest index to the lowest, and
// power-up walks it from the lowest to the highest. Every step can be followed
// by a programmable settle gap. A per-step timeout forces the step to complete
// and raises a sticky error.
//
// Ports
//   clk_i            clock
//   rstn_i           asynchronous active-low reset
//   power_req_i      target state: 1 = on, 0 = sleep (level, sampled in ON/OFF)
//   dom_mask_i       bit k = 1: domain k is gated during sleep
//   settle_cycles_i  idle cycles after each completed step (0 = none)
//   timeout_i        max WAIT cycles per step (0 = disabled)
//   dom_done_i       domain k has reached the level driven on dom_power_o[k]
//   err_clr_i        clears err_o / err_dom_o (a same-cycle timeout wins)
//   dom_power_o      per-domain power request
//   on_o / sleep_o   state is ON / OFF
//   busy_o           sequence in progress
//   err_o            sticky timeout flag
//   err_dom_o        index of the domain that most recently timed out
// ---------------------------------------------------------------------------
module pg_domain_sequencer #(
    parameter int N_DOM = 6,
    parameter int DLY_W = 8,
    parameter int TO_W  = 12
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     power_req_i,
    input  logic [N_DOM-1:0]         dom_mask_i,
    input  logic [DLY_W-1:0]         settle_cycles_i,
    input  logic [TO_W-1:0]          timeout_i,
    input  logic [N_DOM-1:0]         dom_done_i,
    input  logic                     err_clr_i,
    output logic [N_DOM-1:0]         dom_power_o,
    output logic                     on_o,
    output logic                     sleep_o,
    output logic                     busy_o,
    output logic                     err_o,
    output logic [$clog2(N_DOM)-1:0] err_dom_o
);

    localparam int IDX_W = $clog2(N_DOM);
    localparam int CNT_W = (DLY_W > TO_W) ? DLY_W : TO_W;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    typedef enum logic [1:0] {
        ST_ON     = 2'd0,
        ST_OFF    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_dir;
    logic [IDX_W-1:0]   r_idx;
    logic [N_DOM-1:0]   r_mask_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_DOM-1:0]   r_dom_power;
    logic               r_on;
    logic               r_sleep;
    logic               r_busy;
    logic               r_err;
    logic [IDX_W-1:0]   r_err_dom;

    logic               w_hi_vld;
    logic [IDX_W-1:0]   w_hi_idx;
    logic               w_lo_vld;
    logic [IDX_W-1:0]   w_lo_idx;
    logic               w_nx_vld;
    logic [IDX_W-1:0]   w_nx_idx;
    logic               w_blank;
    logic               w_done;
    logic               w_tmo;
    logic               w_step_done;
    logic               w_settle_nz;
    logic               w_settle_end;
    logic               w_advance;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Bit searches. The first down step searches the live mask because it is
    // being latched in the same cycle; every later step uses the latched copy.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_idx = '0;
        for (int k = 0; k < N_DOM; k++) begin
            if (dom_mask_i[k]) begin
                w_hi_vld = 1'b1;
                w_hi_idx = IDX_W'(k);
            end
        end

        w_lo_vld = 1'b0;
        w_lo_idx = '0;
        for (int k = N_DOM - 1; k >= 0; k--) begin
            if (r_mask_q[k]) begin
                w_lo_vld = 1'b1;
                w_lo_idx = IDX_W'(k);
            end
        end

        // Next set bit below r_idx (down) or above r_idx (up); unmasked
        // domains are skipped without spending any cycles.
        w_nx_vld = 1'b0;
        w_nx_idx = '0;
        for (int k = 0; k < N_DOM; k++) begin
            if (r_mask_q[k]) begin
                if (r_dir == DIR_DOWN) begin
                    if (k < int'(r_idx)) begin
                        w_nx_vld = 1'b1;
                        w_nx_idx = IDX_W'(k);
                    end
                end else if ((k > int'(r_idx)) && !w_nx_vld) begin
                    w_nx_vld = 1'b1;
                    w_nx_idx = IDX_W'(k);
                end
            end
        end
    end

    // The first WAIT cycle ignores done: the domain FSM may still report the
    // previous level. The counter saturates, so this cycle never repeats
    // when the timeout is disabled.
    assign w_blank      = (r_cnt == CNT_W'(1));
    assign w_done       = !w_blank && dom_done_i[r_idx];
    assign w_tmo        = (timeout_i != '0) && (r_cnt == CNT_W'(timeout_i)) && !w_done;
    assign w_step_done  = w_done || w_tmo;
    assign w_settle_nz  = (settle_cycles_i != '0);
    assign w_settle_end = (r_cnt >= CNT_W'(settle_cycles_i));
    assign w_cnt_inc    = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    assign w_advance = ((r_state == ST_WAIT) && w_step_done && !w_settle_nz) ||
                       ((r_state == ST_SETTLE) && w_settle_end);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= ST_ON;
            r_dir       <= DIR_DOWN;
            r_idx       <= '0;
            r_mask_q    <= '0;
            r_cnt       <= '0;
            r_dom_power <= '1;
            r_on        <= 1'b1;
            r_sleep     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_err_dom   <= '0;
        end else begin
            if (err_clr_i) begin
                r_err     <= 1'b0;
                r_err_dom <= '0;
            end

            case (r_state)
                ST_ON: begin
                    if (!power_req_i) begin
                        r_mask_q <= dom_mask_i;
                        r_dir    <= DIR_DOWN;
                        r_on     <= 1'b0;
                        if (w_hi_vld) begin
                            r_idx                 <= w_hi_idx;
                            r_dom_power[w_hi_idx] <= 1'b0;
                            r_cnt                 <= CNT_W'(1);
                            r_busy                <= 1'b1;
                            r_state               <= ST_WAIT;
                        end else begin
                            r_sleep <= 1'b1;
                            r_state <= ST_OFF;
                        end
                    end
                end

                ST_OFF: begin
                    if (power_req_i) begin
                        r_dir   <= DIR_UP;
                        r_sleep <= 1'b0;
                        if (w_lo_vld) begin
                            r_idx                 <= w_lo_idx;
                            r_dom_power[w_lo_idx] <= 1'b1;
                            r_cnt                 <= CNT_W'(1);
                            r_busy                <= 1'b1;
                            r_state               <= ST_WAIT;
                        end else begin
                            r_on    <= 1'b1;
                            r_state <= ST_ON;
                        end
                    end
                end

                ST_WAIT: begin
                    if (w_step_done) begin
                        // Written after the clear above so a coincident
                        // timeout keeps the flag set.
                        if (w_tmo) begin
                            r_err     <= 1'b1;
                            r_err_dom <= r_idx;
                        end
                        if (w_settle_nz) begin
                            r_cnt   <= CNT_W'(1);
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                ST_SETTLE: begin
                    if (!w_settle_end) begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    r_state <= ST_ON;
                end
            endcase

            // Step to the next masked domain, or finish the sequence.
            if (w_advance) begin
                if (w_nx_vld) begin
                    r_idx                 <= w_nx_idx;
                    r_dom_power[w_nx_idx] <= ~r_dom_power[w_nx_idx];
                    r_cnt                 <= CNT_W'(1);
                    r_state               <= ST_WAIT;
                end else begin
                    r_busy <= 1'b0;
                    if (r_dir == DIR_DOWN) begin
                        r_sleep <= 1'b1;
                        r_state <= ST_OFF;
                    end else begin
                        r_on    <= 1'b1;
                        r_state <= ST_ON;
                    end
                end
            end
        end
    end

    assign dom_power_o = r_dom_power;
    assign on_o        = r_on;
    assign sleep_o     = r_sleep;
    assign busy_o      = r_busy;
    assign err_o       = r_err;
    assign err_dom_o   = r_err_dom;

endmodule

// File: tb/tb_pg_domain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pg_domain_sequencer
//
// Directed bench for pg_domain_sequencer with N_DOM=6. Each domain answers
// done one cycle after its power request changes (a lagged copy of
// dom_power_o); domains listed in 'stuck' never answer.
// ---------------------------------------------------------------------------
module tb_pg_domain_sequencer;

    localparam int N_DOM = 6;
    localparam int DLY_W = 8;
    localparam int TO_W  = 12;

    logic             clk = 1'b0;
    logic             rstn;
    logic             power_req;
    logic [5:0]       dom_mask;
    logic [7:0]       settle;
    logic [11:0]      timeout;
    logic [5:0]       dom_done;
    logic             err_clr;
    logic [5:0]       dom_power;
    logic             on_s;
    logic             sleep_s;
    logic             busy;
    logic             err;
    logic [2:0]       err_dom;

    logic [5:0]       lag = 6'h3F;
    logic [5:0]       stuck = 6'h00;

    int n_checks = 0;
    int n_errors = 0;

    int cap_n;
    int cap_idx[8];
    int cap_t[8];
    int cap_end;

    always #5 clk = ~clk;

    always @(posedge clk) lag <= dom_power;
    assign dom_done = ~(lag ^ dom_power) & ~stuck;

    pg_domain_sequencer #(
        .N_DOM(N_DOM),
        .DLY_W(DLY_W),
        .TO_W (TO_W)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .power_req_i    (power_req),
        .dom_mask_i     (dom_mask),
        .settle_cycles_i(settle),
        .timeout_i      (timeout),
        .dom_done_i     (dom_done),
        .err_clr_i      (err_clr),
        .dom_power_o    (dom_power),
        .on_o           (on_s),
        .sleep_o        (sleep_s),
        .busy_o         (busy),
        .err_o          (err),
        .err_dom_o      (err_dom)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records every dom_power change (bit index and cycle number, 1 = first
    // cycle after the request is sampled) until the target state is reached
    // or the budget runs out (cap_end stays -1).
    task automatic capture(input bit want_on, input int budget);
        logic [5:0] prev;
        prev    = dom_power;
        cap_n   = 0;
        cap_end = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (dom_power !== prev) begin
                for (int b = 0; b < 6; b++) begin
                    if ((dom_power[b] !== prev[b]) && (cap_n < 8)) begin
                        cap_idx[cap_n] = b;
                        cap_t[cap_n]   = k;
                        cap_n++;
                    end
                end
                prev = dom_power;
            end
            if ((want_on ? on_s : sleep_s) && !busy) begin
                cap_end = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (dom_power !== 6'h3F) begin n_errors++; $display("FAIL reset_power: got %h expected 3f", dom_power); end
        n_checks++; if (on_s !== 1'b1)       begin n_errors++; $display("FAIL reset_on: got %b expected 1", on_s); end
        n_checks++; if (sleep_s !== 1'b0)    begin n_errors++; $display("FAIL reset_sleep: got %b expected 0", sleep_s); end
        n_checks++; if (busy !== 1'b0)       begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (err !== 1'b0)        begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (err_dom !== 3'd0)    begin n_errors++; $display("FAIL reset_err_dom: got %0d expected 0", err_dom); end
        rstn = 1'b1;
        tick();
        n_checks++; if (on_s !== 1'b1)       begin n_errors++; $display("FAIL idle_on: got %b expected 1", on_s); end
    endtask

    task automatic test_full_sequence();
        dom_mask  = 6'h3F;
        settle    = 8'd0;
        timeout   = 12'd0;
        power_req = 1'b0;
        capture(1'b0, 40);
        n_checks++; if (cap_n !== 6) begin n_errors++; $display("FAIL down_count: got %0d expected 6", cap_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (cap_idx[i] !== 5 - i)   begin n_errors++; $display("FAIL down_order[%0d]: got %0d expected %0d", i, cap_idx[i], 5 - i); end
            n_checks++; if (cap_t[i] !== 1 + 2 * i) begin n_errors++; $display("FAIL down_time[%0d]: got %0d expected %0d", i, cap_t[i], 1 + 2 * i); end
        end
        // Last bit cleared at cycle 11, its done seen at 12, OFF shown at 13.
        n_checks++; if (cap_end !== 13)       begin n_errors++; $display("FAIL down_sleep_time: got %0d expected 13", cap_end); end
        n_checks++; if (dom_power !== 6'h00)  begin n_errors++; $display("FAIL down_power: got %h expected 00", dom_power); end
        n_checks++; if (on_s !== 1'b0)        begin n_errors++; $display("FAIL down_on: got %b expected 0", on_s); end

        power_req = 1'b1;
        capture(1'b1, 40);
        n_checks++; if (cap_n !== 6) begin n_errors++; $display("FAIL up_count: got %0d expected 6", cap_n); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (cap_idx[i] !== i)       begin n_errors++; $display("FAIL up_order[%0d]: got %0d expected %0d", i, cap_idx[i], i); end
            n_checks++; if (cap_t[i] !== 1 + 2 * i) begin n_errors++; $display("FAIL up_time[%0d]: got %0d expected %0d", i, cap_t[i], 1 + 2 * i); end
        end
        n_checks++; if (cap_end !== 13)       begin n_errors++; $display("FAIL up_on_time: got %0d expected 13", cap_end); end
        n_checks++; if (dom_power !== 6'h3F)  begin n_errors++; $display("FAIL up_power: got %h expected 3f", dom_power); end
        n_checks++; if (sleep_s !== 1'b0)     begin n_errors++; $display("FAIL up_sleep: got %b expected 0", sleep_s); end
    endtask

    task automatic test_settle_mask();
        dom_mask  = 6'b010010;
        settle    = 8'd3;
        power_req = 1'b0;
        capture(1'b0, 40);
        n_checks++; if (cap_n !== 2)          begin n_errors++; $display("FAIL smask_down_count: got %0d expected 2", cap_n); end
        n_checks++; if (cap_idx[0] !== 4)     begin n_errors++; $display("FAIL smask_down_first: got %0d expected 4", cap_idx[0]); end
        n_checks++; if (cap_idx[1] !== 1)     begin n_errors++; $display("FAIL smask_down_second: got %0d expected 1", cap_idx[1]); end
        n_checks++; if (cap_t[0] !== 1)       begin n_errors++; $display("FAIL smask_down_t0: got %0d expected 1", cap_t[0]); end
        n_checks++; if (cap_t[1] - cap_t[0] !== 5) begin n_errors++; $display("FAIL smask_down_gap: got %0d expected 5", cap_t[1] - cap_t[0]); end
        // Settle also follows the final step: done at 7, settle 8..10, OFF at 11.
        n_checks++; if (cap_end !== 11)       begin n_errors++; $display("FAIL smask_down_end: got %0d expected 11", cap_end); end
        n_checks++; if (dom_power !== 6'b101101) begin n_errors++; $display("FAIL smask_down_power: got %b expected 101101", dom_power); end

        // A mask change while OFF must not reach power-up.
        dom_mask = 6'h3F;
        repeat (2) tick();
        n_checks++; if (dom_power !== 6'b101101) begin n_errors++; $display("FAIL smask_off_hold: got %b expected 101101", dom_power); end
        power_req = 1'b1;
        capture(1'b1, 40);
        n_checks++; if (cap_n !== 2)          begin n_errors++; $display("FAIL smask_up_count: got %0d expected 2", cap_n); end
        n_checks++; if (cap_idx[0] !== 1)     begin n_errors++; $display("FAIL smask_up_first: got %0d expected 1", cap_idx[0]); end
        n_checks++; if (cap_idx[1] !== 4)     begin n_errors++; $display("FAIL smask_up_second: got %0d expected 4", cap_idx[1]); end
        n_checks++; if (cap_t[1] - cap_t[0] !== 5) begin n_errors++; $display("FAIL smask_up_gap: got %0d expected 5", cap_t[1] - cap_t[0]); end
        n_checks++; if (cap_end !== 11)       begin n_errors++; $display("FAIL smask_up_end: got %0d expected 11", cap_end); end
        n_checks++; if (dom_power !== 6'h3F)  begin n_errors++; $display("FAIL smask_up_power: got %h expected 3f", dom_power); end
        settle = 8'd0;
    endtask

    task automatic test_timeout();
        dom_mask  = 6'h3F;
        settle    = 8'd0;
        timeout   = 12'd10;
        stuck     = 6'b000100;
        power_req = 1'b0;
        capture(1'b0, 60);
        n_checks++; if (cap_n !== 6)          begin n_errors++; $display("FAIL tmo_count: got %0d expected 6", cap_n); end
        n_checks++; if (cap_idx[3] !== 2)     begin n_errors++; $display("FAIL tmo_stuck_idx: got %0d expected 2", cap_idx[3]); end
        // Domain 2 enters WAIT at cycle 7; 10th WAIT cycle is 16; domain 1 at 17.
        n_checks++; if (cap_t[4] - cap_t[3] !== 10) begin n_errors++; $display("FAIL tmo_gap: got %0d expected 10", cap_t[4] - cap_t[3]); end
        n_checks++; if (cap_end !== 21)       begin n_errors++; $display("FAIL tmo_end: got %0d expected 21", cap_end); end
        n_checks++; if (err !== 1'b1)         begin n_errors++; $display("FAIL tmo_err: got %b expected 1", err); end
        n_checks++; if (err_dom !== 3'd2)     begin n_errors++; $display("FAIL tmo_err_dom: got %0d expected 2", err_dom); end

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0)         begin n_errors++; $display("FAIL clr_err: got %b expected 0", err); end
        n_checks++; if (err_dom !== 3'd0)     begin n_errors++; $display("FAIL clr_err_dom: got %0d expected 0", err_dom); end

        // Power-up: domain 2 enters WAIT at cycle 5, times out on cycle 14.
        power_req = 1'b1;
        repeat (14) tick();
        n_checks++; if (err !== 1'b0)         begin n_errors++; $display("FAIL coinc_pre_err: got %b expected 0", err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b1)         begin n_errors++; $display("FAIL coinc_err: got %b expected 1", err); end
        n_checks++; if (err_dom !== 3'd2)     begin n_errors++; $display("FAIL coinc_err_dom: got %0d expected 2", err_dom); end
        n_checks++; if (dom_power !== 6'b001111) begin n_errors++; $display("FAIL coinc_power: got %b expected 001111", dom_power); end
        capture(1'b1, 30);
        n_checks++; if (cap_end === -1)       begin n_errors++; $display("FAIL coinc_on: got timeout expected on_o"); end
        stuck   = 6'h00;
        timeout = 12'd0;
    endtask

    task automatic test_back_to_back();
        int k;
        dom_mask  = 6'h3F;
        power_req = 1'b0;
        repeat (5) tick();
        n_checks++; if (dom_power !== 6'b000111) begin n_errors++; $display("FAIL rev_mid_power: got %b expected 000111", dom_power); end
        power_req = 1'b1;
        k = 5;
        while (!sleep_s && k < 40) begin
            tick();
            k++;
        end
        n_checks++; if (k !== 13)             begin n_errors++; $display("FAIL rev_sleep_time: got %0d expected 13", k); end
        n_checks++; if (dom_power !== 6'h00)  begin n_errors++; $display("FAIL rev_sleep_power: got %h expected 00", dom_power); end
        tick();
        n_checks++; if (dom_power !== 6'b000001) begin n_errors++; $display("FAIL rev_up_start: got %b expected 000001", dom_power); end
        n_checks++; if (busy !== 1'b1)        begin n_errors++; $display("FAIL rev_up_busy: got %b expected 1", busy); end
        capture(1'b1, 30);
        n_checks++; if (cap_end === -1)       begin n_errors++; $display("FAIL rev_on: got timeout expected on_o"); end
    endtask

    task automatic test_mask_zero();
        dom_mask  = 6'h00;
        power_req = 1'b0;
        tick();
        n_checks++; if (sleep_s !== 1'b1)     begin n_errors++; $display("FAIL m0_sleep: got %b expected 1", sleep_s); end
        n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL m0_down_busy: got %b expected 0", busy); end
        n_checks++; if (dom_power !== 6'h3F)  begin n_errors++; $display("FAIL m0_down_power: got %h expected 3f", dom_power); end
        power_req = 1'b1;
        tick();
        n_checks++; if (on_s !== 1'b1)        begin n_errors++; $display("FAIL m0_on: got %b expected 1", on_s); end
        n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL m0_up_busy: got %b expected 0", busy); end
        n_checks++; if (dom_power !== 6'h3F)  begin n_errors++; $display("FAIL m0_up_power: got %h expected 3f", dom_power); end
    endtask

    task automatic test_async_reset();
        dom_mask  = 6'h3F;
        power_req = 1'b0;
        repeat (3) tick();
        n_checks++; if (busy !== 1'b1)        begin n_errors++; $display("FAIL ar_pre_busy: got %b expected 1", busy); end
        n_checks++; if (err !== 1'b1)         begin n_errors++; $display("FAIL ar_pre_err: got %b expected 1", err); end
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (dom_power !== 6'h3F)  begin n_errors++; $display("FAIL ar_power: got %h expected 3f", dom_power); end
        n_checks++; if (on_s !== 1'b1)        begin n_errors++; $display("FAIL ar_on: got %b expected 1", on_s); end
        n_checks++; if (busy !== 1'b0)        begin n_errors++; $display("FAIL ar_busy: got %b expected 0", busy); end
        n_checks++; if (err !== 1'b0)         begin n_errors++; $display("FAIL ar_err: got %b expected 0", err); end
        power_req = 1'b1;
        #2;
        rstn = 1'b1;
        tick();
        n_checks++; if (on_s !== 1'b1)        begin n_errors++; $display("FAIL ar_after_on: got %b expected 1", on_s); end
        n_checks++; if (dom_power !== 6'h3F)  begin n_errors++; $display("FAIL ar_after_power: got %h expected 3f", dom_power); end
    endtask

    initial begin
        rstn      = 1'b0;
        power_req = 1'b1;
        dom_mask  = 6'h3F;
        settle    = 8'd0;
        timeout   = 12'd0;
        err_clr   = 1'b0;

        test_reset();
        test_full_sequence();
        test_settle_mask();
        test_timeout();
        test_back_to_back();
        test_mask_zero();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
